adcdac_2g_cmd_framer: RTL

- Command/response framer directly upstream of the 2Gsps ADC/DAC UART control block: converts one software register-access request into a 4-byte command on the UART byte interface, then parses the 3-byte reply.
- Drives user_tx_data/user_tx_val and watches user_tx_full on the UART block; consumes its one-cycle user_rx_val/user_rx_data pulses.
- Provides busy/done/error status and the returned 16-bit data to the software register layer.

---
 rtl/adcdac_2g_cmd_framer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/adcdac_2g_cmd_framer.sv
`default_nettype none
// ============================================================================
// adcdac_2g_cmd_framer
//   Sends a 4-byte register command to the UART block and parses the 3-byte reply.
//   Revision: 1.0
// ============================================================================
module adcdac_2g_cmd_framer #(
   parameter int unsigned TIMEOUT_CYCLES = 2500000,
   parameter logic [7:0]  OP_WRITE       = 8'h57,
   parameter logic [7:0]  OP_READ        = 8'h52
) (
   input  logic        fpga_clk,
   input  logic        fpga_rst_n,
   input  logic        cmd_start,
   input  logic        cmd_write,
   input  logic [7:0]  cmd_addr,
   input  logic [15:0] cmd_wdata,
   output logic [7:0]  tx_data,
   output logic        tx_val,
   input  logic        tx_full,
   input  logic [7:0]  rx_data,
   input  logic        rx_val,
   output logic        busy,
   output logic        done,
   output logic [15:0] rsp_data,
   output logic        err_nack,
   output logic        err_timeout,
   output logic [7:0]  stray_count
);

   localparam int unsigned      CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]       RSP_ACK  = 8'h41;
   localparam logic [7:0]       RSP_NACK = 8'h4E;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SEND    = 3'd1,
      S_GAP     = 3'd2,
      S_WAIT_R0 = 3'd3,
      S_WAIT_R1 = 3'd4,
      S_WAIT_R2 = 3'd5,
      S_FINISH  = 3'd6
   } state_t;

   state_t           state;
   state_t           next_state;
   logic             op_write;
   logic [7:0]       addr;
   logic [15:0]      wdata;
   logic [1:0]       idx;
   logic             nack_flag;
   logic [7:0]       data_hi;
   logic [CNT_W-1:0] tmo_cnt;
   logic             accept;
   logic             stray;
   logic             tmo_fire;
   logic             tmo_end;
   logic             in_wait;
   logic [7:0]       frame_byte;

   assign tmo_end = (tmo_cnt == TMO_LAST);
   assign in_wait = (state == S_WAIT_R0) || (state == S_WAIT_R1) || (state == S_WAIT_R2);
   assign busy    = (state != S_IDLE) && (state != S_FINISH);
   assign done    = (state == S_FINISH);
   assign tx_data = tx_val ? frame_byte : 8'h00;

   always_comb begin
      frame_byte = 8'h00;
      case (idx)
         2'd0:    frame_byte = op_write ? OP_WRITE : OP_READ;
         2'd1:    frame_byte = addr;
         2'd2:    frame_byte = wdata[15:8];
         default: frame_byte = wdata[7:0];
      endcase
   end

   always_ff @(posedge fpga_clk or negedge fpga_rst_n) begin
      if (!fpga_rst_n) state <= S_IDLE;
      else             state <= next_state;
   end

   // A byte arriving on the timeout cycle takes priority over the timeout.
   always_comb begin
      next_state = state;
      tx_val     = 1'b0;
      accept     = 1'b0;
      stray      = 1'b0;
      tmo_fire   = 1'b0;
      case (state)
         S_IDLE: begin
            stray = rx_val;
            if (cmd_start) begin
               accept     = 1'b1;
               next_state = S_SEND;
            end
         end
         S_SEND: begin
            stray = rx_val;
            if (!tx_full) begin
               tx_val     = 1'b1;
               next_state = S_GAP;
            end
         end
         S_GAP: begin
            stray      = rx_val;
            next_state = (idx == 2'd3) ? S_WAIT_R0 : S_SEND;
         end
         S_WAIT_R0: begin
            if (rx_val) begin
               if (rx_data == RSP_ACK || rx_data == RSP_NACK) next_state = S_WAIT_R1;
               else                                          stray      = 1'b1;
            end else if (tmo_end) begin
               tmo_fire   = 1'b1;
               next_state = S_FINISH;
            end
         end
         S_WAIT_R1: begin
            if (rx_val) begin
               next_state = S_WAIT_R2;
            end else if (tmo_end) begin
               tmo_fire   = 1'b1;
               next_state = S_FINISH;
            end
         end
         S_WAIT_R2: begin
            if (rx_val || tmo_end) begin
               tmo_fire   = !rx_val;
               next_state = S_FINISH;
            end
         end
         S_FINISH: begin
            stray      = rx_val;
            next_state = S_IDLE;
         end
         default: next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge fpga_clk or negedge fpga_rst_n) begin
      if (!fpga_rst_n) begin
         op_write    <= 1'b0;
         addr        <= 8'h00;
         wdata       <= 16'h0000;
         idx         <= 2'd0;
         nack_flag   <= 1'b0;
         data_hi     <= 8'h00;
         tmo_cnt     <= '0;
         rsp_data    <= 16'h0000;
         err_nack    <= 1'b0;
         err_timeout <= 1'b0;
         stray_count <= 8'h00;
      end else begin
         if (accept) begin
            op_write    <= cmd_write;
            addr        <= cmd_addr;
            wdata       <= cmd_wdata;
            idx         <= 2'd0;
            nack_flag   <= 1'b0;
            err_nack    <= 1'b0;
            err_timeout <= 1'b0;
         end
         if (state == S_GAP) begin
            if (idx == 2'd3) tmo_cnt <= '0;
            else             idx     <= idx + 2'd1;
         end else if (in_wait && !tmo_end) begin
            tmo_cnt <= tmo_cnt + 1'b1;
         end
         if (state == S_WAIT_R0 && rx_val) begin
            if (rx_data == RSP_NACK)     nack_flag <= 1'b1;
            else if (rx_data == RSP_ACK) nack_flag <= 1'b0;
         end
         if (state == S_WAIT_R1 && rx_val) data_hi <= rx_data;
         if (state == S_WAIT_R2 && rx_val) begin
            rsp_data <= {data_hi, rx_data};
            err_nack <= nack_flag;
         end
         if (tmo_fire) err_timeout <= 1'b1;
         if (stray && stray_count != 8'hFF) stray_count <= stray_count + 8'h01;
      end
   end

endmodule
`default_nettype wire
